// File: rtl/seq_detector_param_if.sv
// Serial bit stream in, detector status out.
// The source side drives din/din_valid/clear and the detector drives the status signals back.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic              din_valid;
    logic              din;
    logic              clear;
    logic              match;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  match_cnt;
    logic              cnt_ovf;

    modport master (
        output din_valid, din, clear,
        input  match, fill, match_cnt, cnt_ovf
    );

    modport slave (
        input  din_valid, din, clear,
        output match, fill, match_cnt, cnt_ovf
    );
endinterface

// File: rtl/seq_detector_param.sv
// Masked sliding-window pattern detector with overlap/non-overlap restart,
// a saturating match counter and a sticky overflow flag.
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter logic [PAT_W-1:0] MASK    = '1,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input logic                clk,
    input logic                rst,
    seq_detector_param_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window;
    logic [FILL_W-1:0] fill;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              cnt_ovf;

    logic [PAT_W-1:0]  nxt;
    logic [FILL_W-1:0] nfill;
    logic              hit;

    always_comb begin
        nxt   = {window[PAT_W-2:0], bus.din};
        nfill = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit   = bus.din_valid && (nfill == FILL_FULL) &&
                (((nxt ^ PATTERN) & MASK) == '0);
    end

    // clear and rst share one path, so a completing bit in a clear cycle is dropped
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            window    <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_ovf   <= 1'b0;
        end else begin
            match <= hit;
            if (bus.din_valid) begin
                window <= nxt;
                fill   <= (hit && !OVERLAP) ? '0 : nfill;
            end
            if (hit) begin
                if (match_cnt != '1)
                    match_cnt <= match_cnt + CNT_W'(1);
                else
                    cnt_ovf <= 1'b1;
            end
        end
    end

    assign bus.match     = match;
    assign bus.fill      = fill;
    assign bus.match_cnt = match_cnt;
    assign bus.cnt_ovf   = cnt_ovf;
endmodule
